// File: rtl/ahb_multi_arbiter.sv
// N-master AHB-lite arbiter: registered IDLE/OWNED ownership FSM, fixed-priority
// or round-robin selection, and an optional per-grant beat limit.
module ahb_multi_arbiter #(
    parameter int NMASTERS  = 2,
    parameter int ADDR_W    = 32,
    parameter int RR_MODE   = 0,
    parameter int MAX_BEATS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NMASTERS-1:0]          HRequestIn,
    input  logic [NMASTERS-1:0]          HWriteIn,
    input  logic [NMASTERS*ADDR_W-1:0]   HAddrIn,
    input  logic                         HReady,
    output logic [NMASTERS-1:0]          HReadyOut,
    output logic                         HRequest,
    output logic                         HWrite,
    output logic [ADDR_W-1:0]            HAddr,
    output logic [NMASTERS-1:0]          Grant,
    output logic                         Busy,
    output logic                         dbg_state,
    output logic [7:0]                   dbg_beat_cnt
);
    // Handshake: a beat completes for the owner in any OWNED cycle where
    // HRequestIn[owner] and HReady are both high; HReadyOut forwards HReady to
    // the owner only, so non-owners never see a completed beat.

    localparam int OW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int BW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [BW-1:0] SAT_CNT  = BW'(MAX_BEATS);
    localparam logic [BW-1:0] LAST_CNT = (MAX_BEATS > 0) ? BW'(MAX_BEATS - 1) : '0;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t         state, state_nx;
    logic [OW-1:0]  owner, owner_nx;
    logic [OW-1:0]  last_owner, last_owner_nx;
    logic [BW-1:0]  beat_cnt, beat_cnt_nx;

    logic           found;
    logic [OW-1:0]  winner;
    logic [OW-1:0]  rr_base;
    int             idx;
    logic           own_req;
    logic           own_beat;
    logic           limit_hit;
    logic           release_own;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NMASTERS - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

    // Descending loops leave the highest-precedence match as the final winner.
    // On release the search starts after the releasing owner, so it rotates.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = 0;
        rr_base = (state == OWNED) ? owner : last_owner;
        if (RR_MODE == 0) begin
            for (int i = NMASTERS - 1; i >= 0; i--) begin
                if (HRequestIn[i]) begin
                    found  = 1'b1;
                    winner = OW'(i);
                end
            end
        end else begin
            for (int k = NMASTERS; k >= 1; k--) begin
                idx = (int'(rr_base) + k) % NMASTERS;
                if (HRequestIn[idx]) begin
                    found  = 1'b1;
                    winner = OW'(idx);
                end
            end
        end
    end

    assign own_req     = HRequestIn[owner];
    assign own_beat    = own_req & HReady;
    assign limit_hit   = (MAX_BEATS != 0) && own_beat && (beat_cnt == LAST_CNT);
    assign release_own = !own_req || limit_hit;

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        beat_cnt_nx   = beat_cnt;
        HReadyOut     = '0;
        HRequest      = 1'b0;
        HWrite        = 1'b0;
        HAddr         = '0;
        Grant         = '0;
        Busy          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx    = OWNED;
                    owner_nx    = winner;
                    beat_cnt_nx = '0;
                end
            end
            OWNED: begin
                HAddr            = HAddrIn[int'(owner)*ADDR_W +: ADDR_W];
                HWrite           = HWriteIn[owner] & own_req;
                HRequest         = own_req;
                HReadyOut[owner] = HReady;
                Grant[owner]     = 1'b1;
                Busy             = 1'b1;
                if (release_own) begin
                    last_owner_nx = owner;
                    if (found) begin
                        owner_nx    = winner;
                        beat_cnt_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (own_beat && (beat_cnt != SAT_CNT)) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dbg_state    = (state == OWNED);
    assign dbg_beat_cnt = 8'(beat_cnt);
endmodule
